logit_accumulator: RTL and testbench

- Producer side of the logits valid/ready interface consumed by the class-decision stage.
- Sums per-timestep output-layer contributions for 3 classes over one sample window of up to NUM_STEPS timesteps, using saturating signed adders.
- Presents the packed logits vector with a held-stable valid/ready handshake.
- Sits between the output SNN layer and argmax.

---
 rtl/logit_accumulator.sv | 98 +++++++++
 tb/tb_logit_accumulator.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/logit_accumulator.sv
// Accumulates three signed per-timestep class contributions over one sample
// window with saturating adders, then presents the logits on a held valid/ready port.
`timescale 1ns/1ps

module logit_accumulator #(
  parameter int IN_WIDTH   = 16,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_STEPS  = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_valid,
  output logic                               i_ready,
  input  logic [3*IN_WIDTH-1:0]              i_data,
  input  logic                               i_last,
  output logic                               o_valid,
  input  logic                               o_ready,
  output logic [3*DATA_WIDTH-1:0]            o_logits,
  output logic [$clog2(NUM_STEPS+1)-1:0]     o_steps,
  output logic                               o_sat
);

  localparam int SW = $clog2(NUM_STEPS + 1);
  localparam logic signed [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic {ACCUM = 1'b0, OUTPUT = 1'b1} state_t;

  state_t                        state;
  logic signed [DATA_WIDTH-1:0]  acc      [3];
  logic signed [DATA_WIDTH-1:0]  acc_next [3];
  logic [2:0]                    clamp;
  logic [SW-1:0]                 step_cnt;
  logic [SW-1:0]                 step_next;
  logic                          sat_flag;
  logic                          sat_next;
  logic                          frame_end;

  // Each lane adds at DATA_WIDTH+1 bits; the top two bits disagreeing means the rail was crossed.
  for (genvar k = 0; k < 3; k++) begin : g_lane
    logic signed [IN_WIDTH-1:0]   in_k;
    logic signed [DATA_WIDTH:0]   sum_full;
    logic                         overflow;

    assign in_k     = i_data[k*IN_WIDTH +: IN_WIDTH];
    assign sum_full = {acc[k][DATA_WIDTH-1], acc[k]}
                    + {{(DATA_WIDTH+1-IN_WIDTH){in_k[IN_WIDTH-1]}}, in_k};
    assign overflow = sum_full[DATA_WIDTH] != sum_full[DATA_WIDTH-1];
    assign clamp[k] = overflow;
    assign acc_next[k] = !overflow          ? sum_full[DATA_WIDTH-1:0]
                       : sum_full[DATA_WIDTH] ? MIN_VAL : MAX_VAL;
  end

  assign step_next = step_cnt + SW'(1);
  assign sat_next  = sat_flag | (|clamp);
  // A redundant i_last on the final allowed beat collapses into the same single frame end.
  assign frame_end = i_last || (step_next == SW'(NUM_STEPS));

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACCUM;
      i_ready  <= 1'b1;
      o_valid  <= 1'b0;
      o_logits <= '0;
      o_steps  <= '0;
      o_sat    <= 1'b0;
      step_cnt <= '0;
      sat_flag <= 1'b0;
      for (int k = 0; k < 3; k++) acc[k] <= '0;
    end else if (state == ACCUM) begin
      if (i_valid) begin
        for (int k = 0; k < 3; k++) acc[k] <= acc_next[k];
        step_cnt <= step_next;
        sat_flag <= sat_next;
        if (frame_end) begin
          o_logits <= {acc_next[2], acc_next[1], acc_next[0]};
          o_steps  <= step_next;
          o_sat    <= sat_next;
          o_valid  <= 1'b1;
          i_ready  <= 1'b0;
          state    <= OUTPUT;
        end
      end
    end else begin
      // Presented outputs stay untouched on handoff; only the working sums restart.
      if (o_ready) begin
        for (int k = 0; k < 3; k++) acc[k] <= '0;
        step_cnt <= '0;
        sat_flag <= 1'b0;
        o_valid  <= 1'b0;
        i_ready  <= 1'b1;
        state    <= ACCUM;
      end
    end
  end

endmodule

// File: tb/tb_logit_accumulator.sv
// Bench for logit_accumulator: two instances (32-bit and 16-bit sums) share one stimulus
// stream; directed table rows plus random traffic are checked against a queue-based model.
`timescale 1ns/1ps

module tb_logit_accumulator;

  localparam int IW = 16;
  localparam int NS = 4;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_valid = 1'b0;
  logic            i_last = 1'b0;
  logic            o_ready = 1'b0;
  logic [3*IW-1:0] i_data = '0;

  logic            a_i_ready, a_o_valid, a_o_sat;
  logic [95:0]     a_o_logits;
  logic [SW-1:0]   a_o_steps;
  logic            s_i_ready, s_o_valid, s_o_sat;
  logic [47:0]     s_o_logits;
  logic [SW-1:0]   s_o_steps;

  always #5 clk = ~clk;

  logit_accumulator #(.IN_WIDTH(IW), .DATA_WIDTH(32), .NUM_STEPS(NS)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(a_i_ready), .i_data(i_data),
    .i_last(i_last), .o_valid(a_o_valid), .o_ready(o_ready), .o_logits(a_o_logits),
    .o_steps(a_o_steps), .o_sat(a_o_sat));

  logit_accumulator #(.IN_WIDTH(IW), .DATA_WIDTH(16), .NUM_STEPS(NS)) dut_s (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(s_i_ready), .i_data(i_data),
    .i_last(i_last), .o_valid(s_o_valid), .o_ready(o_ready), .o_logits(s_o_logits),
    .o_steps(s_o_steps), .o_sat(s_o_sat));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint la(input int k);
    logic signed [31:0] t;
    t = a_o_logits[k*32 +: 32];
    return longint'(t);
  endfunction

  function automatic longint ls(input int k);
    logic signed [15:0] t;
    t = s_o_logits[k*16 +: 16];
    return longint'(t);
  endfunction

  // Reference model: the beats of the open sample are kept as a list; a frame's result is
  // their running sum clamped to the output range after every addition.
  typedef struct { int d0; int d1; int d2; } beat_t;
  beat_t  q[$];
  bit     m_busy;
  longint m_la[3];
  longint m_ls[3];
  int     m_steps;
  bit     m_sat_a, m_sat_s;

  function automatic void frame_sum(input int w, output longint r[3], output bit sat);
    longint hi, lo, s;
    int     d;
    hi  = (longint'(1) <<< (w - 1)) - 1;
    lo  = -(longint'(1) <<< (w - 1));
    sat = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s = 0;
      foreach (q[b]) begin
        d = (k == 0) ? q[b].d0 : (k == 1) ? q[b].d1 : q[b].d2;
        s = s + d;
        if (s > hi) begin s = hi; sat = 1'b1; end
        if (s < lo) begin s = lo; sat = 1'b1; end
      end
      r[k] = s;
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    m_busy  = 1'b0;
    m_steps = 0;
    m_sat_a = 1'b0;
    m_sat_s = 1'b0;
    for (int k = 0; k < 3; k++) begin m_la[k] = 0; m_ls[k] = 0; end
  endfunction

  function automatic void model_edge();
    beat_t b;
    if (!m_busy) begin
      if (i_valid) begin
        b.d0 = int'($signed(i_data[15:0]));
        b.d1 = int'($signed(i_data[31:16]));
        b.d2 = int'($signed(i_data[47:32]));
        q.push_back(b);
        if (i_last || q.size() == NS) begin
          frame_sum(32, m_la, m_sat_a);
          frame_sum(16, m_ls, m_sat_s);
          m_steps = q.size();
          m_busy  = 1'b1;
        end
      end
    end else if (o_ready) begin
      m_busy = 1'b0;
      q.delete();
    end
  endfunction

  task automatic compare_model();
    check("a_o_valid", a_o_valid, m_busy);
    check("a_i_ready", a_i_ready, !m_busy);
    check("s_o_valid", s_o_valid, m_busy);
    check("s_i_ready", s_i_ready, !m_busy);
    check("a_o_steps", a_o_steps, m_steps);
    check("s_o_steps", s_o_steps, m_steps);
    check("a_o_sat", a_o_sat, m_sat_a);
    check("s_o_sat", s_o_sat, m_sat_s);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("a_logit%0d", k), la(k), m_la[k]);
      check($sformatf("s_logit%0d", k), ls(k), m_ls[k]);
    end
  endtask

  // Drive one cycle from a falling edge, advance the model at the rising edge, compare after.
  task automatic cycle(input bit v, input bit l, input bit r, input int d0, input int d1, input int d2);
    i_valid = v;
    i_last  = l;
    o_ready = r;
    i_data  = {16'(d2), 16'(d1), 16'(d0)};
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    i_last  = 1'b0;
    o_ready = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("rst_a_o_valid", a_o_valid, 0);
    check("rst_a_i_ready", a_i_ready, 1);
    check("rst_a_logits", longint'(a_o_logits == '0), 1);
    check("rst_a_steps", a_o_steps, 0);
    check("rst_a_sat", a_o_sat, 0);
    check("rst_s_o_valid", s_o_valid, 0);
    check("rst_s_logits", longint'(s_o_logits == '0), 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compare_model();
  endtask

  typedef struct {
    bit v; bit l; bit r;
    int d0; int d1; int d2;
    bit chk; bit ev;
    longint a0; longint a1; longint a2;
    longint s0; longint s1; longint s2;
    int steps; bit sa; bit ss;
  } vec_t;
  vec_t tbl[$];

  function automatic void add_in(input bit v, input bit l, input bit r, input int d0, input int d1, input int d2);
    tbl.push_back('{v, l, r, d0, d1, d2, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0});
  endfunction

  function automatic void add_chk(input bit v, input bit l, input bit r, input int d0, input int d1, input int d2,
                                  input bit ev, input longint a0, input longint a1, input longint a2,
                                  input longint s0, input longint s1, input longint s2,
                                  input int steps, input bit sa, input bit ss);
    tbl.push_back('{v, l, r, d0, d1, d2, 1'b1, ev, a0, a1, a2, s0, s1, s2, steps, sa, ss});
  endfunction

  function automatic int rnd_data();
    if ($urandom_range(0, 3) == 0) return int'($signed(16'($urandom)));
    return int'($urandom_range(0, 200)) - 100;
  endfunction

  initial begin
    // Basic four-beat sum, stall, handoff.
    add_in (1, 0, 0, 1, -2, 3);
    add_in (1, 0, 0, 2, 0, -1);
    add_in (1, 0, 0, 0, 5, 1);
    add_chk(1, 0, 0, -1, 1, 1,   1, 2, 4, 4,   2, 4, 4,   4, 0, 0);
    add_chk(1, 0, 0, 9, 9, 9,    1, 2, 4, 4,   2, 4, 4,   4, 0, 0);
    add_chk(1, 0, 1, 8, 8, 8,    0, 2, 4, 4,   2, 4, 4,   4, 0, 0);
    // Early i_last, then five stalled cycles of changing data.
    add_in (1, 0, 0, 10, 0, 0);
    add_chk(1, 1, 0, 0, 7, -3,   1, 10, 7, -3, 10, 7, -3, 2, 0, 0);
    for (int i = 0; i < 5; i++)
      add_chk(1, 0, 0, i + 5, -i, 3 * i, 1, 10, 7, -3, 10, 7, -3, 2, 0, 0);
    add_chk(1, 0, 1, 50, 50, 50, 0, 10, 7, -3, 10, 7, -3, 2, 0, 0);
    // Single-beat sample; handoff ignores the concurrent beat; idle keeps outputs.
    add_chk(1, 1, 0, 3, 3, 3,    1, 3, 3, 3,   3, 3, 3,   1, 0, 0);
    add_chk(1, 0, 1, 100, 100, 100, 0, 3, 3, 3, 3, 3, 3,  1, 0, 0);
    for (int i = 0; i < 3; i++)
      add_chk(0, 0, 0, 77, 77, 77, 0, 3, 3, 3, 3, 3, 3,   1, 0, 0);
    // i_last on the final allowed beat.
    for (int i = 0; i < 3; i++) add_in(1, 0, 0, 1, 1, 1);
    add_chk(1, 1, 0, 1, 1, 1,    1, 4, 4, 4,   4, 4, 4,   4, 0, 0);
    add_chk(0, 0, 1, 0, 0, 0,    0, 4, 4, 4,   4, 4, 4,   4, 0, 0);
    // Back-to-back frames with o_ready held high: one bubble, 3 then 7.
    add_in (1, 0, 1, 0, 0, 1);
    add_chk(1, 1, 1, 0, 0, 2,    1, 0, 0, 3,   0, 0, 3,   2, 0, 0);
    add_chk(1, 0, 1, 0, 0, 3,    0, 0, 0, 3,   0, 0, 3,   2, 0, 0);
    add_in (1, 0, 1, 0, 0, 3);
    add_chk(1, 1, 1, 0, 0, 4,    1, 0, 0, 7,   0, 0, 7,   2, 0, 0);
    add_chk(0, 0, 1, 0, 0, 0,    0, 0, 0, 7,   0, 0, 7,   2, 0, 0);
    // Saturation on both rails for the 16-bit instance.
    for (int i = 0; i < 3; i++) add_in(1, 0, 0, 32767, -32768, 0);
    add_chk(1, 0, 0, 32767, -32768, 0, 1, 131068, -131072, 0, 32767, -32768, 0, 4, 0, 1);
    add_in (0, 0, 1, 0, 0, 0);
    // Off the rail after a clamp.
    add_in (1, 0, 0, 32767, 0, 0);
    add_in (1, 0, 0, 32767, 0, 0);
    add_chk(1, 1, 0, -10, 0, 0,  1, 65524, 0, 0, 32757, 0, 0, 3, 0, 1);
    add_in (0, 0, 1, 0, 0, 0);
    add_chk(1, 1, 0, 1, 2, 3,    1, 1, 2, 3,   1, 2, 3,   1, 0, 0);
    add_in (0, 0, 1, 0, 0, 0);

    model_reset();
    @(negedge clk);
    do_reset();

    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].l, tbl[i].r, tbl[i].d0, tbl[i].d1, tbl[i].d2);
      if (tbl[i].chk) begin
        check($sformatf("row%0d_o_valid", i), a_o_valid, tbl[i].ev);
        check($sformatf("row%0d_i_ready", i), a_i_ready, !tbl[i].ev);
        check($sformatf("row%0d_a0", i), la(0), tbl[i].a0);
        check($sformatf("row%0d_a1", i), la(1), tbl[i].a1);
        check($sformatf("row%0d_a2", i), la(2), tbl[i].a2);
        check($sformatf("row%0d_s0", i), ls(0), tbl[i].s0);
        check($sformatf("row%0d_s1", i), ls(1), tbl[i].s1);
        check($sformatf("row%0d_s2", i), ls(2), tbl[i].s2);
        check($sformatf("row%0d_steps", i), a_o_steps, tbl[i].steps);
        check($sformatf("row%0d_sat_a", i), a_o_sat, tbl[i].sa);
        check($sformatf("row%0d_sat_s", i), s_o_sat, tbl[i].ss);
      end
    end

    // Reset in the middle of a sample discards the partial sums.
    cycle(1, 0, 0, 5, 5, 5);
    cycle(1, 0, 0, 5, 5, 5);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1, 1, 1);
    check("rst_seq_o_valid", a_o_valid, 1);
    check("rst_seq_a0", la(0), 4);
    check("rst_seq_a1", la(1), 4);
    check("rst_seq_a2", la(2), 4);
    check("rst_seq_steps", a_o_steps, 4);
    check("rst_seq_s2", ls(2), 4);
    cycle(0, 0, 1, 0, 0, 0);

    // Random traffic, including one reset while busy.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
            rnd_data(), rnd_data(), rnd_data());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
